// File: rtl/bus_ram_responder.sv
// Bus RAM target: 2**ADDR_WIDTH x 32-bit word RAM; optional BUS_RAM_RESP_ERR_EN adds bus_err_o for out-of-range accesses.
// Latency: writes commit at the ack edge; read resp is exactly RD_LATENCY cycles after its ack, in ack order.
// Backpressure: writes never stall; reads stall at MAX_OUTSTANDING in flight unless one retires this cycle.
module bus_ram_responder #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
`ifdef BUS_RAM_RESP_ERR_EN
    output logic        bus_err_o,
`endif
    output logic [31:0] bus_rdata_bo
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] widx;
    logic                  in_range;
    logic                  unused_addr;
    logic                  rd_ack;
    logic                  wr_ack;
    logic                  resp_now;
    logic [31:0]           rd_word;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]           dat_q [RD_LATENCY];
    logic [31:0]           dat_d [RD_LATENCY];

    assign widx = bus_addr_bi[ADDR_WIDTH+1:2];

`ifdef BUS_RAM_RESP_ERR_EN
    assign in_range    = (bus_addr_bi[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign unused_addr = ^bus_addr_bi[1:0];
`else
    // Upper address bits are don't-care: the RAM aliases across the whole space.
    assign in_range    = 1'b1;
    assign unused_addr = ^{bus_addr_bi[31:ADDR_WIDTH+2], bus_addr_bi[1:0], BASE_ADDR};
`endif

    assign resp_now  = vld_q[RD_LATENCY-1];
    // A retiring read frees its slot in the same cycle, so a full pipeline still streams.
    assign bus_ack_o = arst_n_i & bus_req_i & (bus_we_i | (cnt_q < MAX_OUT) | resp_now);
    assign rd_ack    = bus_ack_o & ~bus_we_i;
    assign wr_ack    = bus_ack_o & bus_we_i;
    assign rd_word   = in_range ? mem[widx] : 32'h0;

    always_comb begin
        vld_d[0] = rd_ack;
        dat_d[0] = rd_ack ? rd_word : 32'h0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rd_ack && !resp_now) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!rd_ack && resp_now) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // RAM contents survive reset; only the read pipeline and counter are cleared.
    always_ff @(posedge clk_i) begin
        if (wr_ack && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be_bi[b]) begin
                    mem[widx][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign bus_resp_o   = resp_now;
    assign bus_rdata_bo = resp_now ? dat_q[RD_LATENCY-1] : 32'h0;

`ifdef BUS_RAM_RESP_ERR_EN
    logic [RD_LATENCY-1:0] err_q, err_d;
    logic                  wr_err_q, wr_err_d;

    always_comb begin
        err_d[0] = rd_ack & ~in_range;
        for (int i = 1; i < RD_LATENCY; i++) begin
            err_d[i] = err_q[i-1];
        end
        wr_err_d = wr_ack & ~in_range;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus_err_o = (resp_now & err_q[RD_LATENCY-1]) | wr_err_q;
`endif

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: queue-based reference model of the bus plus directed and random scenarios.
`timescale 1ns/1ps
module tb_bus_ram_responder;
    localparam int L    = 3;
    localparam int MAXO = 2;
    localparam int LB   = 2;
`ifdef BUS_RAM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, resp, err;
    logic [31:0] rdata;
    logic        mirror_b, req_b_drv, req_b, ack_b, resp_b;
    logic [31:0] rdata_b;

    assign req_b = mirror_b ? req : req_b_drv;

    bus_ram_responder #(.ADDR_WIDTH(10), .RD_LATENCY(L), .MAX_OUTSTANDING(MAXO), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .bus_req_i(req), .bus_we_i(we), .bus_addr_bi(addr),
        .bus_be_bi(be), .bus_wdata_bi(wdata), .bus_ack_o(ack), .bus_resp_o(resp),
`ifdef BUS_RAM_RESP_ERR_EN
        .bus_err_o(err),
`endif
        .bus_rdata_bo(rdata));

`ifdef BUS_RAM_RESP_ERR_EN
    logic err_b;
`else
    assign err = 1'b0;
`endif

    bus_ram_responder #(.ADDR_WIDTH(10), .RD_LATENCY(LB), .MAX_OUTSTANDING(1), .BASE_ADDR(32'h0)) dut_b (
        .clk_i(clk), .arst_n_i(arst_n), .bus_req_i(req_b), .bus_we_i(we), .bus_addr_bi(addr),
        .bus_be_bi(be), .bus_wdata_bi(wdata), .bus_ack_o(ack_b), .bus_resp_o(resp_b),
`ifdef BUS_RAM_RESP_ERR_EN
        .bus_err_o(err_b),
`endif
        .bus_rdata_bo(rdata_b));

    typedef struct {
        int          due;
        logic [31:0] dat;
        bit          err;
    } tok_t;

    tok_t        q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] got_q[$];
    int          cyc, n_cmp, n_bad;
    int          last_ack_cyc, last_resp_cyc, wr_err_cyc;
    logic        last_resp_err;

    // One bus cycle on the main target: drive, compare against the model, then advance the model.
    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input string tag);
        bit          exp_resp, exp_ack, exp_err, inr;
        logic [31:0] exp_rd;
        int          wi;
        @(negedge clk);
        req = r; we = w; addr = a; be = b; wdata = d;
        #1;
        exp_resp = (q.size() > 0) && (q[0].due == cyc);
        exp_rd   = exp_resp ? q[0].dat : 32'h0;
        exp_ack  = r && (w || q.size() < MAXO || exp_resp);
        exp_err  = (exp_resp && q[0].err) || (wr_err_cyc == cyc);
        n_cmp++;
        if (ack !== exp_ack) begin
            n_bad++; $display("FAIL %s ack cyc=%0d got=%b exp=%b", tag, cyc, ack, exp_ack);
        end
        n_cmp++;
        if (resp !== exp_resp) begin
            n_bad++; $display("FAIL %s resp cyc=%0d got=%b exp=%b", tag, cyc, resp, exp_resp);
        end
        n_cmp++;
        if (rdata !== exp_rd) begin
            n_bad++; $display("FAIL %s rdata cyc=%0d got=%h exp=%h", tag, cyc, rdata, exp_rd);
        end
`ifdef BUS_RAM_RESP_ERR_EN
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++; $display("FAIL %s err cyc=%0d got=%b exp=%b", tag, cyc, err, exp_err);
        end
`endif
        if (resp === 1'b1) begin
            got_q.push_back(rdata);
            last_resp_cyc = cyc;
            last_resp_err = err;
        end
        if (exp_resp) void'(q.pop_front());
        wi  = int'(a[5:2]);
        inr = !ERR_EN || (a[31:12] == 20'h0);
        if (exp_ack && !w) begin
            q.push_back('{cyc + L, inr ? ref_mem[wi] : 32'h0, !inr});
            last_ack_cyc = cyc;
        end
        if (exp_ack && w) begin
            if (inr) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) ref_mem[wi][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                wr_err_cyc = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "idle");
    endtask

    task automatic test_reset();
        arst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
        mirror_b = 1'b0; req_b_drv = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
        n_cmp++; if (resp !== 1'b0) begin n_bad++; $display("FAIL rst_resp got=%b exp=0", resp); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        n_cmp++; if (ack_b !== 1'b0) begin n_bad++; $display("FAIL rst_ack_b got=%b exp=0", ack_b); end
        @(negedge clk);
        req = 1'b0; req_b_drv = 1'b0; arst_n = 1'b1;
        q.delete(); wr_err_cyc = -1;
    endtask

    task automatic init_mem();
        mirror_b = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom, "init");
        mirror_b = 1'b0;
    endtask

    task automatic test_latency_limit_b();
        logic [7:0]  ack_bits, resp_bits;
        logic [31:0] exp_q[$], got_b[$];
        int          k;
        k = 0; ack_bits = '0; resp_bits = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'((k + 1) * 4); req_b_drv = (k < 3);
            #1;
            ack_bits[c]  = ack_b;
            resp_bits[c] = resp_b;
            if (resp_b === 1'b1) got_b.push_back(rdata_b);
            if (ack_b === 1'b1) begin exp_q.push_back(ref_mem[k + 1]); k++; end
            cyc++;
        end
        req_b_drv = 1'b0;
        n_cmp++; if (ack_bits !== 8'h15) begin n_bad++; $display("FAIL b_ack_pattern got=%b exp=00010101", ack_bits); end
        n_cmp++; if (resp_bits !== 8'h54) begin n_bad++; $display("FAIL b_resp_pattern got=%b exp=01010100", resp_bits); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= got_b.size() || i >= exp_q.size() || got_b[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL b_data[%0d] got_n=%0d exp_n=%0d", i, got_b.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_basic();
        int ack_c;
        got_q.delete(); last_ack_cyc = -100;
        step(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "t1_wr");
        step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, "t1_rd");
        ack_c = last_ack_cyc;
        idle(L + 1);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL t1_data n=%0d exp one resp of deadbeef", got_q.size()); end
        n_cmp++; if (last_resp_cyc - ack_c != L) begin
            n_bad++; $display("FAIL t1_latency got=%0d exp=%0d", last_resp_cyc - ack_c, L); end
    endtask

    task automatic test_byte_enable();
        got_q.delete();
        step(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, "t2_wr0");
        step(1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "t2_wr1");
        step(1'b1, 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, "t2_wr_be0");
        step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, "t2_rd");
        idle(L + 1);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h11BB33DD) begin
            n_bad++; $display("FAIL t2_be n=%0d got=%h exp=11bb33dd", got_q.size(), got_q.size() ? got_q[0] : 32'h0); end
    endtask

    task automatic test_raw_hazard();
        got_q.delete();
        step(1'b1, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, "t4_wr0");
        step(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, "t4_rd0");
        step(1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, "t4_wr1");
        step(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, "t4_rd1");
        idle(L + 1);
        n_cmp++; if (got_q.size() != 2 || got_q[0] !== 32'h0BADF00D || got_q[1] !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL t4_order n=%0d exp 0badf00d then cafef00d", got_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ack_bits;
        logic [31:0] exp_q[$];
        int          k;
        got_q.delete(); k = 0; ack_bits = '0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, 32'((k % 16) * 4), 4'h0, 32'h0, "b2b");
            ack_bits[c] = ack;
            if (ack === 1'b1) begin exp_q.push_back(ref_mem[k % 16]); k++; end
        end
        idle(L + 1);
        n_cmp++; if (ack_bits !== 8'hDB) begin n_bad++; $display("FAIL b2b_ack_pattern got=%b exp=11011011", ack_bits); end
        n_cmp++; if (got_q != exp_q) begin n_bad++; $display("FAIL b2b_data got_n=%0d exp_n=%0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, "t5_rd0");
        step(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, "t5_rd1");
        @(negedge clk);
        arst_n = 1'b0; req = 1'b1; we = 1'b0;
        #1;
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL t5_rst_ack got=%b exp=0", ack); end
        n_cmp++; if (resp !== 1'b0 || rdata !== 32'h0) begin
            n_bad++; $display("FAIL t5_rst_resp got=%b/%h exp=0/0", resp, rdata); end
        cyc++;
        @(negedge clk);
        arst_n = 1'b1; req = 1'b0;
        q.delete(); wr_err_cyc = -1; got_q.delete();
        cyc++;
        idle(L + 2);
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL t5_stale_resp got=%0d exp=0", got_q.size()); end
        step(1'b1, 1'b0, 32'hC, 4'h0, 32'h0, "t5_rd2");
        step(1'b1, 1'b0, 32'h14, 4'h0, 32'h0, "t5_rd3");
        idle(L + 1);
        n_cmp++; if (got_q.size() != 2 || got_q[0] !== ref_mem[3] || got_q[1] !== ref_mem[5]) begin
            n_bad++; $display("FAIL t5_after n=%0d exp 2 resps", got_q.size()); end
    endtask

    task automatic test_alias();
        got_q.delete();
        step(1'b1, 1'b1, 32'h0, 4'hF, 32'h5A5AA5A5, "t6_wr");
        step(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, "t6_rd");
        idle(L + 1);
`ifdef BUS_RAM_RESP_ERR_EN
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h0 || last_resp_err !== 1'b1) begin
            n_bad++; $display("FAIL t6_err_rd n=%0d err=%b exp rdata 0 err 1", got_q.size(), last_resp_err); end
        step(1'b1, 1'b1, 32'h2000, 4'hF, 32'h12345678, "t6_err_wr");
        idle(2);
        step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, "t6_rd_back");
        idle(L + 1);
`else
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h5A5AA5A5) begin
            n_bad++; $display("FAIL t6_alias n=%0d exp 5a5aa5a5", got_q.size()); end
`endif
    endtask

    task automatic test_random();
        bit          r, w, pend;
        logic [31:0] a, d;
        logic [3:0]  b;
        pend = 1'b0; r = 1'b0; w = 1'b0; a = '0; d = '0; b = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                r = ($urandom_range(0, 3) != 0);
                w = 1'($urandom_range(0, 1));
                a = {ERR_EN ? 20'h0 : 20'($urandom), 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
                b = 4'($urandom);
                d = $urandom;
            end
            step(r, w, a, b, d, "rand");
            pend = r && (ack !== 1'b1);
        end
        idle(L + 1);
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rand_drain pending=%0d exp=0", q.size()); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; wr_err_cyc = -1;
        last_ack_cyc = -100; last_resp_cyc = -100; last_resp_err = 1'b0;
        mirror_b = 1'b0; req_b_drv = 1'b0;
        test_reset();
        init_mem();
        test_latency_limit_b();
        test_basic();
        test_byte_enable();
        test_raw_hazard();
        test_back_to_back();
        test_reset_midflight();
        test_alias();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
